// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field positions, handler address.
package cp0_pkg;

  localparam logic [4:0] RegSr    = 5'd12;
  localparam logic [4:0] RegCause = 5'd13;
  localparam logic [4:0] RegEpc   = 5'd14;
  localparam logic [4:0] RegPrid  = 5'd15;

  localparam logic [4:0] ExcInt     = 5'd0;
  localparam logic [4:0] ExcAdEL    = 5'd4;
  localparam logic [4:0] ExcAdES    = 5'd5;
  localparam logic [4:0] ExcSyscall = 5'd8;
  localparam logic [4:0] ExcRI      = 5'd10;
  localparam logic [4:0] ExcOv      = 5'd12;

  localparam int unsigned ImLsb  = 10;
  localparam int unsigned ImMsb  = 15;
  localparam int unsigned ExlBit = 1;
  localparam int unsigned IeBit  = 0;
  localparam int unsigned BdBit  = 31;
  localparam int unsigned IpLsb  = 10;
  localparam int unsigned IpMsb  = 15;
  localparam int unsigned ExcLsb = 2;
  localparam int unsigned ExcMsb = 6;

  localparam logic [31:0] HandlerAddr = 32'h0000_4180;

  function automatic logic [31:0] sr_pack(input logic [5:0] im, input logic exl, input logic ie);
    logic [31:0] v;
    v = '0;
    v[ImMsb:ImLsb] = im;
    v[ExlBit]      = exl;
    v[IeBit]       = ie;
    return v;
  endfunction

  function automatic logic [31:0] cause_pack(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] v;
    v = '0;
    v[BdBit]         = bd;
    v[IpMsb:IpLsb]   = ip;
    v[ExcMsb:ExcLsb] = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage <-> CP0 signal bundle; master is the pipeline side, slave is cp0.
interface cp0_if;
  logic [31:0] M_PC;
  logic [4:0]  M_EXCcode;
  logic        M_Delayslot;
  logic [5:0]  HWInt;
  logic        WrEn;
  logic [4:0]  Addr;
  logic [31:0] WData;
  logic        EXLClr;
  logic [31:0] RData;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output M_PC, M_EXCcode, M_Delayslot, HWInt, WrEn, Addr, WData, EXLClr,
    input  RData, EPCOut, Req
  );

  modport slave (
    input  M_PC, M_EXCcode, M_Delayslot, HWInt, WrEn, Addr, WData, EXLClr,
    output RData, EPCOut, Req
  );
endinterface

// File: rtl/cp0_req_gen.sv
// Combinational interrupt/exception request generation and ExcCode selection.
module cp0_req_gen
  import cp0_pkg::*;
(
  input  logic       i_rst_n,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [5:0] i_im,
  input  logic [5:0] i_hw_int,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_req,
  output logic [4:0] o_exc_sel
);
  logic w_exc_req;

  assign o_int_req = i_ie & ~i_exl & (|(i_hw_int & i_im));
  assign w_exc_req = ~i_exl & (i_exc_code != ExcInt);
  // Gated by reset so Req drops the instant reset asserts, even with a pending code.
  assign o_req     = i_rst_n & (o_int_req | w_exc_req);
  assign o_exc_sel = o_int_req ? ExcInt : i_exc_code;
endmodule

// File: rtl/cp0.sv
// CP0 register file (SR/Cause/EPC) with exception capture; CP0_PRID_EN enables PRId at reg 15.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0007
) (
  input logic    clk,
  input logic    reset,
  cp0_if.slave   bus
);
  logic [5:0]  r_im, w_im_nxt;
  logic        r_exl, w_exl_nxt;
  logic        r_ie, w_ie_nxt;
  logic        r_bd, w_bd_nxt;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc, w_exc_nxt;
  logic [31:0] r_epc, w_epc_nxt;
  logic        w_int_req;
  logic        w_req;
  logic [4:0]  w_exc_sel;
  logic [31:0] w_rdata;

  cp0_req_gen u_req_gen (
    .i_rst_n    (reset),
    .i_ie       (r_ie),
    .i_exl      (r_exl),
    .i_im       (r_im),
    .i_hw_int   (bus.HWInt),
    .i_exc_code (bus.M_EXCcode),
    .o_int_req  (w_int_req),
    .o_req      (w_req),
    .o_exc_sel  (w_exc_sel)
  );

  always_comb begin
    w_im_nxt  = r_im;
    w_exl_nxt = r_exl;
    w_ie_nxt  = r_ie;
    w_bd_nxt  = r_bd;
    w_exc_nxt = r_exc;
    w_epc_nxt = r_epc;
    if (w_req) begin
      w_exl_nxt = 1'b1;
      w_bd_nxt  = bus.M_Delayslot;
      w_exc_nxt = w_exc_sel;
      w_epc_nxt = bus.M_Delayslot ? bus.M_PC - 32'd4 : bus.M_PC;
    end else begin
      if (bus.WrEn) begin
        case (bus.Addr)
          RegSr: begin
            w_im_nxt  = bus.WData[ImMsb:ImLsb];
            w_exl_nxt = bus.WData[ExlBit];
            w_ie_nxt  = bus.WData[IeBit];
          end
          RegEpc:  w_epc_nxt = bus.WData;
          default: ;
        endcase
      end
      // eret clear is applied after any same-cycle SR write.
      if (bus.EXLClr) w_exl_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im  <= '0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= '0;
      r_exc <= '0;
      r_epc <= '0;
    end else begin
      r_im  <= w_im_nxt;
      r_exl <= w_exl_nxt;
      r_ie  <= w_ie_nxt;
      r_bd  <= w_bd_nxt;
      r_ip  <= bus.HWInt;
      r_exc <= w_exc_nxt;
      r_epc <= w_epc_nxt;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.Addr)
      RegSr:    w_rdata = sr_pack(r_im, r_exl, r_ie);
      RegCause: w_rdata = cause_pack(r_bd, r_ip, r_exc);
      RegEpc:   w_rdata = r_epc;
`ifdef CP0_PRID_EN
      RegPrid:  w_rdata = PRID;
`endif
      default:  ;
    endcase
  end

`ifndef CP0_PRID_EN
  logic w_unused_prid;
  assign w_unused_prid = ^PRID;
`endif

  assign bus.RData  = w_rdata;
  assign bus.EPCOut = r_epc;
  assign bus.Req    = w_req;
endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: reset, mtc0/mfc0, exception capture, masking, eret.
module tb_cp0;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  cp0_if bus ();

  cp0 #(.PRID(32'h0000_0007)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    bus.Addr = a;
    #1;
    check(tag, bus.RData, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.M_PC = '0; bus.M_EXCcode = '0; bus.M_Delayslot = 1'b0; bus.HWInt = '0;
    bus.WrEn = 1'b0; bus.Addr = '0; bus.WData = '0; bus.EXLClr = 1'b0;
    #2 reset = 1'b0;
    bus.M_EXCcode = 5'd10;
    #1;
    check("req_forced_in_reset", {31'd0, bus.Req}, 32'd0);
    check("epcout_reset", bus.EPCOut, 32'd0);
    rd(5'd12, 32'd0, "sr_reset");
    rd(5'd13, 32'd0, "cause_reset");
    rd(5'd14, 32'd0, "epc_reset");
    bus.M_EXCcode = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Write-mask on SR, no write-through, Cause read-only.
    bus.WrEn = 1'b1; bus.Addr = 5'd12; bus.WData = 32'hFFFF_FFFF;
    #1 check("sr_no_write_through", bus.RData, 32'd0);
    tick();
    bus.WrEn = 1'b0;
    rd(5'd12, 32'h0000_FC03, "sr_write_mask");
    bus.WrEn = 1'b1; bus.Addr = 5'd13; bus.WData = 32'hFFFF_FFFF;
    tick();
    bus.WrEn = 1'b0;
    rd(5'd13, 32'd0, "cause_readonly");
    rd(5'd0, 32'd0, "unimpl_reg0");
`ifdef CP0_PRID_EN
    rd(5'd15, 32'h0000_0007, "prid_read");
`else
    rd(5'd15, 32'd0, "prid_absent");
`endif
    bus.WrEn = 1'b1; bus.Addr = 5'd12; bus.WData = 32'd0;
    tick();
    bus.WrEn = 1'b0;

    // Delay-slot exception: EPC = PC - 4, BD set.
    bus.M_EXCcode = 5'd10; bus.M_PC = 32'h0000_3010; bus.M_Delayslot = 1'b1;
    #1 check("exc_req_same_cycle", {31'd0, bus.Req}, 32'd1);
    tick();
    #1 check("req_masked_by_exl", {31'd0, bus.Req}, 32'd0);
    bus.M_EXCcode = '0; bus.M_Delayslot = 1'b0;
    check("epc_delayslot", bus.EPCOut, 32'h0000_300C);
    rd(5'd13, 32'h8000_0028, "cause_bd_ri");
    rd(5'd12, 32'h0000_0002, "sr_exl_set");

    // Interrupt beats a simultaneous overflow exception.
    bus.WrEn = 1'b1; bus.Addr = 5'd12; bus.WData = 32'h0000_0401;
    tick();
    bus.WrEn = 1'b0;
    rd(5'd12, 32'h0000_0401, "sr_ie_im0");
    bus.HWInt = 6'b000001; bus.M_EXCcode = 5'd12; bus.M_PC = 32'h0000_3020;
    #1 check("int_req", {31'd0, bus.Req}, 32'd1);
    tick();
    rd(5'd13, 32'h0000_0400, "cause_int_priority");
    check("epc_int", bus.EPCOut, 32'h0000_3020);
    rd(5'd12, 32'h0000_0403, "sr_after_int");

    // EXL masks until eret; new request the cycle after the clear edge.
    bus.M_EXCcode = 5'd4;
    #1 check("exl_masks_all", {31'd0, bus.Req}, 32'd0);
    bus.EXLClr = 1'b1;
    #1 check("exlclr_cycle_no_req", {31'd0, bus.Req}, 32'd0);
    tick();
    bus.EXLClr = 1'b0; bus.M_PC = 32'h0000_3030;
    rd(5'd12, 32'h0000_0401, "sr_exl_cleared");
    check("req_after_eret", {31'd0, bus.Req}, 32'd1);
    tick();
    rd(5'd13, 32'h0000_0400, "cause_int_again");
    check("epc_int_again", bus.EPCOut, 32'h0000_3030);
    bus.HWInt = '0; bus.M_EXCcode = '0;

    // SR write setting EXL together with eret: clear wins.
    bus.WrEn = 1'b1; bus.Addr = 5'd12; bus.WData = 32'h0000_0403; bus.EXLClr = 1'b1;
    tick();
    bus.WrEn = 1'b0; bus.EXLClr = 1'b0;
    rd(5'd12, 32'h0000_0401, "sr_write_then_clear");

    // mtc0 EPC in the exception cycle is dropped.
    bus.WrEn = 1'b1; bus.Addr = 5'd14; bus.WData = 32'h0000_1234;
    bus.M_EXCcode = 5'd5; bus.M_PC = 32'h0000_3040;
    #1 check("req_with_wren", {31'd0, bus.Req}, 32'd1);
    tick();
    bus.WrEn = 1'b0; bus.M_EXCcode = '0;
    #1 check("epc_write_dropped", bus.EPCOut, 32'h0000_3040);
    rd(5'd13, 32'h0000_0014, "cause_ades");

    // Asynchronous reset mid-exception.
    @(negedge clk);
    bus.HWInt = 6'b000001; bus.M_EXCcode = 5'd8;
    #1 reset = 1'b0;
    #1;
    check("req_drop_on_reset", {31'd0, bus.Req}, 32'd0);
    check("epcout_async_reset", bus.EPCOut, 32'd0);
    rd(5'd12, 32'd0, "sr_async_reset");
    rd(5'd13, 32'd0, "cause_async_reset");
    rd(5'd14, 32'd0, "epc_async_reset");
    bus.HWInt = '0; bus.M_EXCcode = '0;
    tick();
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
